// File: rtl/note_scheduler.sv
// note_scheduler: spawns, moves and judges falling notes across the drum lanes
module note_scheduler #(
  parameter int LANES      = 5,
  parameter int BAND_Y     = 384,
  parameter int WINDOW     = 16,
  parameter int STEP       = 8,
  parameter int BEAT_TICKS = 4,
  parameter int SONG_LEN   = 256,
  parameter int ADDR_W     = 8,
  parameter int MAX_MISS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  tick,
  input  logic [LANES-1:0]      buttons,
  output logic [ADDR_W-1:0]     pat_addr,
  input  logic [LANES-1:0]      pat_data,
  output logic [LANES-1:0]      note_active,
  output logic [10*LANES-1:0]   note_y,
  output logic [2:0]            hit_count,
  output logic                  miss_pulse,
  output logic [2:0]            miss_count,
  output logic                  lost,
  output logic                  song_done
);
  localparam int BW = BEAT_TICKS > 1 ? $clog2(BEAT_TICKS) : 1;
  localparam logic [9:0] ZLO = 10'(BAND_Y - WINDOW);
  localparam logic [10:0] ZHI = 11'(BAND_Y + WINDOW);
  typedef enum logic [1:0] {IDLE, PLAY, LOST, DONE} state_t;
  state_t state, state_n;
  logic [BW-1:0] beat_cnt, beat_cnt_n;
  logic [ADDR_W-1:0] pat_addr_n;
  logic fetched_all, fetched_all_n, live, beat;
  logic [LANES-1:0] prev, press, hit, miss, active_n;
  logic [9:0] y [LANES];
  logic [9:0] y_n [LANES];
  logic [3:0] hc, mc, miss_sum;
  logic [2:0] miss_total_n;
  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_y
      assign note_y[10*g +: 10] = y[g];
    end
  endgenerate
  assign lost = state == LOST;
  assign song_done = state == DONE;
  // per-lane judge, then move/miss, then spawn; plus beat, fetch and state decisions
  always_comb begin
    live = state == PLAY && run;
    press = buttons & ~prev & {LANES{live}};
    beat = live && tick && beat_cnt == '0 && !fetched_all;
    hc = '0;
    mc = '0;
    for (int i = 0; i < LANES; i++) begin
      hit[i] = press[i] && note_active[i] && y[i] >= ZLO && {1'b0, y[i]} <= ZHI;
      active_n[i] = note_active[i] && !hit[i];
      miss[i] = live && tick && active_n[i] && ({1'b0, y[i]} + 11'(STEP) > ZHI);
      y_n[i] = (live && tick && active_n[i] && !miss[i]) ? y[i] + 10'(STEP) : y[i];
      active_n[i] = active_n[i] && !miss[i];
      y_n[i] = (beat && pat_data[i] && !active_n[i]) ? 10'd0 : y_n[i];
      active_n[i] = active_n[i] || (beat && pat_data[i]);
      hc = hc + 4'(hit[i]);
      mc = mc + 4'(miss[i]);
    end
    miss_sum = {1'b0, miss_count} + mc;
    miss_total_n = miss_sum > 4'd7 ? 3'd7 : miss_sum[2:0];
    beat_cnt_n = (live && tick) ? (beat_cnt == BW'(BEAT_TICKS - 1) ? '0 : beat_cnt + 1'b1) : beat_cnt;
    fetched_all_n = fetched_all || (beat && pat_addr == ADDR_W'(SONG_LEN - 1));
    pat_addr_n = (beat && pat_addr != ADDR_W'(SONG_LEN - 1)) ? pat_addr + 1'b1 : pat_addr;
    state_n = (state == IDLE && run) ? PLAY :
              (live && miss_total_n >= 3'(MAX_MISS)) ? LOST :
              (live && fetched_all_n && active_n == '0) ? DONE : state;
  end
  // state and lane registers; loss wipes every lane on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prev <= '0;
      pat_addr <= '0;
      beat_cnt <= '0;
      fetched_all <= 1'b0;
      note_active <= '0;
      hit_count <= '0;
      miss_pulse <= 1'b0;
      miss_count <= '0;
      for (int i = 0; i < LANES; i++) y[i] <= '0;
    end else begin
      state <= state_n;
      prev <= buttons;
      pat_addr <= pat_addr_n;
      beat_cnt <= beat_cnt_n;
      fetched_all <= fetched_all_n;
      note_active <= state_n == LOST ? '0 : active_n;
      hit_count <= hc[2:0];
      miss_pulse <= |miss;
      miss_count <= miss_total_n;
      for (int i = 0; i < LANES; i++) y[i] <= y_n[i];
    end
  end
endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Sequences the five falling note lanes of the drum game.
- Fetches a song pattern row every beat and spawns notes into free lanes.
- Advances every active note by one step per speed tick.
- Judges drum button presses against the static hit band and reports hits, misses, loss and song completion to the scoring and top-level game logic.
- Sits between the game-state machine (run), the speed-tick generator (tick), the pattern ROM and the lane renderers/scorer.

Parameters:
- LANES, 5, number of lanes and buttons.
- BAND_Y, 384, Y coordinate of the static hit band.
- WINDOW, 16, hit half-window; hit zone is BAND_Y-WINDOW..BAND_Y+WINDOW inclusive.
- STEP, 8, pixels a note moves per tick.
- BEAT_TICKS, 4, ticks per pattern row.
- SONG_LEN, 256, pattern rows in the song.
- ADDR_W, 8, pattern address width.
- MAX_MISS, 3, misses that end the game.
- Constraint: BAND_Y+WINDOW+STEP < 1024.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  game running level (comenzar from game FSM).
- tick  in  1  one-cycle speed pulse (clk32 domain-aligned).
- buttons  in  LANES  synchronized drum button levels.
- pat_addr  out  ADDR_W  pattern ROM address.
- pat_data  in  LANES  lane mask for pat_addr; combinational, valid same cycle.
- note_active  out  LANES  lane holds a note.
- note_y  out  10*LANES  Y per lane, lane i at bits [10i+9:10i].
- hit_count  out  3  hits judged this cycle (one-cycle valid).
- miss_pulse  out  1  at least one miss this cycle.
- miss_count  out  3  saturating miss total.
- lost  out  1  game lost level.
- song_done  out  1  song completed level.

Behaviour:
- Reset value of every output and register is 0: state IDLE, pat_addr 0, beat_cnt 0.
- States:
  - IDLE → PLAY when run=1.
  - PLAY with run=0 holds everything frozen; ticks and presses are ignored, but button history is still sampled.
  - PLAY → LOST when miss_count reaches MAX_MISS; note_active is cleared.
  - PLAY → DONE when the last row has been fetched and note_active==0.
  - LOST and DONE are terminal until reset; lost and song_done are their respective levels.
- Press detection: buttons registered into prev each clk. A press in lane i is buttons[i]&~prev[i], valid only in PLAY with run=1.
- Judge (cycle N, registered results visible at N+1):
  - A press on an active lane with y in the hit zone is a hit: the lane is cleared and counted in hit_count.
  - A press outside the zone, or on an empty lane, is ignored.
  - Judging uses the pre-tick y, so a hit wins over a simultaneous tick.
- Tick processing (tick=1, PLAY, run=1):
  - Every active, non-hit lane gets y += STEP.
  - If the new y > BAND_Y+WINDOW, the lane is cleared and counted as a miss.
  - Misses add to miss_count (saturating at 7) and raise miss_pulse.
- Beat:
  - On a tick with beat_cnt==0 and rows remaining, lanes with pat_data set and not active (after this cycle's hits) spawn at y=0.
  - A freshly spawned note does not move on its spawn tick.
  - A spawn into a busy lane is dropped silently.
  - pat_addr increments after the fetch; after row SONG_LEN-1 an internal fetched_all flag sets and pat_addr holds.
  - beat_cnt counts 0..BEAT_TICKS-1 on ticks, wrapping to 0.
  - The first tick after entering PLAY is a beat.
- Same-cycle ordering:
  - Hit judging first, then movement/miss, then spawn.
  - Multiple lane hits in one cycle are summed into hit_count (max 5).
  - A miss and a hit may co-occur on different lanes.
  - The LOST transition takes effect on the cycle miss_count reaches MAX_MISS, even if hits occur in the same cycle.
- Reset asserted mid-song clears everything immediately, with no drain.

Test Plan:
1. Reset, then run=1, one tick with pat_data=00001 → next cycle: note_active=00001, note_y lane0=0, pat_addr=1; hit_count=0, lost=0.
2. Lane0 note advanced 48 ticks (y=384), press button0 → hit_count=1 for one cycle, note_active[0]=0, miss_count=0.
3. Lane0 note left unpressed to y=400, next tick → y would be 408, so miss_pulse=1, miss_count=1, lane cleared; a press at y=360 is ignored.
4. Lane2 at y=400, press and tick in the same cycle → hit_count=1, no miss.
5. Three consecutive misses → lost=1 on the third, note_active=0; further ticks and presses change nothing until reset; then reset → all outputs 0.
6. SONG_LEN=4, rows 00001 every beat → rows 1–3 dropped (lane busy), only one note falls. After it is hit, song_done=1 and pat_addr holds at 3. With run dropped mid-song, note_y stays frozen across ticks.
